// File: rtl/line_tap_reader_pkg.sv
// Shared geometry for the median filter path: pixel width, line width, column pointer width.
// Line delay, tap reader and median core import these so their line lengths agree.
package line_tap_reader_pkg;

   localparam int LTR_DATA_LENGTH = 8;
   localparam int LTR_W           = 100;
   localparam int LTR_CW          = $clog2(LTR_W);

   // Lines seen since start of frame; taps are only meaningful once two full lines are stored.
   typedef enum logic [1:0] {
      PRIME_LINE0 = 2'd0,
      PRIME_LINE1 = 2'd1,
      PRIME_DONE  = 2'd2
   } prime_t;

endpackage

// File: rtl/line_tap_reader_line_store.sv
// One image line of pixels: combinational read and enabled write at a shared pointer.
// Zero read latency, write lands on the clock edge; no backpressure of its own.
module line_store #(
   parameter int DATA_LENGTH = 8,
   parameter int W           = 100,
   parameter int CW          = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CW-1:0]          ptr,
   input  logic                   we,
   input  logic [DATA_LENGTH-1:0] wdata,
   output logic [DATA_LENGTH-1:0] rdata
);

   logic [DATA_LENGTH-1:0] mem [W];

   assign rdata = mem[ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < W; i++) mem[i] <= '0;
      end else if (we) begin
         mem[ptr] <= wdata;
      end
   end

endmodule

// File: rtl/line_tap_reader.sv
// Raster pixel stream in, vertical {top, mid, bot} column out, one registered stage (1 cycle).
// Valid/ready: in_ready = !out_valid || out_ready, so a stalled output freezes pointer, priming and line stores.
module line_tap_reader
   import line_tap_reader_pkg::*;
#(
   parameter int DATA_LENGTH = LTR_DATA_LENGTH,
   parameter int W           = LTR_W,
   parameter int CW          = LTR_CW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_LENGTH-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_sof,
   output logic                   in_ready,
   output logic [DATA_LENGTH-1:0] out_top,
   output logic [DATA_LENGTH-1:0] out_mid,
   output logic [DATA_LENGTH-1:0] out_bot,
   output logic [CW-1:0]          out_col,
   output logic                   out_eol,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic [CW-1:0]          ptr;
   logic [CW-1:0]          ptr_nxt;
   logic [CW-1:0]          idx;
   logic                   accept;
   logic                   last;
   prime_t                 prime;
   prime_t                 prime_nxt;
   logic [DATA_LENGTH-1:0] line0_rd;
   logic [DATA_LENGTH-1:0] line1_rd;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // A start-of-frame pixel always lands in column 0, wherever the pointer was.
   assign idx      = in_sof ? '0 : ptr;
   assign last     = (idx == CW'(W - 1));
   assign ptr_nxt  = last ? '0 : idx + CW'(1);

   always_comb begin
      prime_nxt = prime;
      if (accept) begin
         if (in_sof)
            prime_nxt = PRIME_LINE0;
         else if (last && prime == PRIME_LINE0)
            prime_nxt = PRIME_LINE1;
         else if (last && prime == PRIME_LINE1)
            prime_nxt = PRIME_DONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prime <= PRIME_LINE0;
         ptr   <= '0;
      end else begin
         prime <= prime_nxt;
         if (accept) ptr <= ptr_nxt;
      end
   end

   line_store #(.DATA_LENGTH(DATA_LENGTH), .W(W), .CW(CW)) u_line0 (
      .clk   (clk),
      .reset (reset),
      .ptr   (idx),
      .we    (accept),
      .wdata (in_data),
      .rdata (line0_rd)
   );

   line_store #(.DATA_LENGTH(DATA_LENGTH), .W(W), .CW(CW)) u_line1 (
      .clk   (clk),
      .reset (reset),
      .ptr   (idx),
      .we    (accept),
      .wdata (line0_rd),
      .rdata (line1_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_top   <= '0;
         out_mid   <= '0;
         out_bot   <= '0;
         out_col   <= '0;
         out_eol   <= 1'b0;
      end else if (accept) begin
         // The sof pixel restarts priming, so it is never emitted even if priming was complete.
         out_valid <= (prime == PRIME_DONE) && !in_sof;
         out_top   <= line1_rd;
         out_mid   <= line0_rd;
         out_bot   <= in_data;
         out_col   <= idx;
         out_eol   <= last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/line_tap_reader.md
Name: line_tap_reader

Overview:
- Read-side companion to the median filter's shift-register line delay.
- Accepts a raster pixel stream and keeps the two previous image lines in circular storage addressed by one pointer.
- For each accepted pixel it emits a vertical 3-tap column {top, mid, bot} to the sort/median stage.
- Output is a one-entry registered stage with a valid/ready handshake, so the median stage can stall the stream; this replaces the single-bit stall flag.

Parameters:
- DATA_LENGTH, 8: pixel width in bits (shared macro value).
- W, 100: line width in pixels; depth of each line store.
- CW, 7: column counter width; must satisfy 2^CW >= W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_LENGTH  incoming pixel.
- in_valid  in  1  in_data is valid.
- in_sof  in  1  start of frame; meaningful only with in_valid.
- in_ready  out  1  block can accept a pixel this cycle.
- out_top  out  DATA_LENGTH  pixel two lines above the current one.
- out_mid  out  DATA_LENGTH  pixel one line above.
- out_bot  out  DATA_LENGTH  current pixel.
- out_col  out  CW  column index of out_bot.
- out_eol  out  1  out_col == W-1.
- out_valid  out  1  output column is valid.
- out_ready  in  1  downstream accepts the output column.

Behaviour:
- Reset (reset==0, async):
  - out_valid=0, out_top/mid/bot=0, out_col=0, out_eol=0.
  - ptr=0, prime=0, both line stores cleared to 0.
  - in_ready=1 after reset is released.
- in_ready = !out_valid || out_ready. This is combinational; in_ready must not depend on in_valid.
- Accept = in_valid && in_ready. Only an accepted cycle changes ptr, the line stores, or the counters.
- On accept, with col = ptr:
  - line1[ptr] <= line0[ptr]; line0[ptr] <= in_data.
  - out_top <= old line1[ptr]; out_mid <= old line0[ptr]; out_bot <= in_data.
  - out_col <= ptr; out_eol <= (ptr == W-1).
  - ptr <= (ptr == W-1) ? 0 : ptr+1.
- Latency: exactly 1 cycle from accept to the taps appearing on the outputs.
- Priming counter prime (0..2):
  - Increments when an accepted pixel has ptr == W-1; saturates at 2.
  - out_valid <= 1 on an accept made while prime == 2. The first two lines are stored but never emitted.
- in_sof handling: an accepted pixel with in_sof=1 is treated as column 0 of line 0.
  - The pixel is written at index 0; the next ptr is 1.
  - prime is forced to 0, so the pixel is not emitted. Line-store contents are kept; they are overwritten before use.
- in_sof arriving mid-line is legal and aborts the partial line.
- If ptr == W-1 and in_sof=1 on the same accept, in_sof wins: prime=0 and the next ptr is 1.
- Output clears: out_valid && out_ready && no accept -> out_valid <= 0.
- Drain and refill in the same cycle (out_valid && out_ready && accept): outputs load the new column and out_valid stays 1 (no bubble).
- Stall: out_valid && !out_ready.
  - in_ready=0.
  - All outputs, ptr, prime and both line stores hold exactly.
- Reset asserted mid-line: everything returns to reset state; the next frame must begin with in_sof or at column 0.
- Pointer arithmetic: unsigned, width CW; wraps explicitly at W-1, never at 2^CW.

Decomposition:
- Shared package / macro header holds DATA_LENGTH, W and CW, derived from W, so the line delay, this block and the median core agree.
- One natural sub-module: line_store. It is W x DATA_LENGTH, with a combinational read at ptr, a write at ptr when enabled, and async active-low clear. It is instantiated twice (line0, line1).
- Priming, pointer and handshake control stay in the top module.

Test Plan (bench uses W=4, DATA_LENGTH=8):
- Reset, then in_valid=0 -> out_valid=0, all outputs 0, in_ready=1.
- in_sof on the first pixel, then 12 pixels with values 1..12, out_ready=1:
  - No output for pixels 1..8.
  - Pixel 9 gives top=1, mid=5, bot=9, col=0.
  - Pixel 12 gives top=4, mid=8, bot=12, col=3, eol=1.
- Same stream with out_ready=0 held for 3 cycles after the first output:
  - in_ready=0 during the stall.
  - Outputs hold at 1/5/9.
  - Pixel 10 is accepted the cycle out_ready returns; no pixel is lost or duplicated.
- Continuous in_valid=1 with out_ready=1 after priming -> one output per cycle with no bubbles; col sequence 0,1,2,3,0.
- in_sof reasserted at column 2 of line 3 -> out_valid stays 0 for the next 8 accepts; the first emitted column after that is col=0.
- Assert reset during a stall with out_valid=1 -> out_valid=0 immediately (async); ptr=0 after release.
